// File: rtl/pwm_gen_channel.sv
// rtl/pwm_gen_channel.sv - single-channel PWM with shadowed period/duty, dead-time complementary output and sticky irq
module pwm_gen_channel #(
    parameter int CNT_WIDTH = 16,
    parameter int DT_WIDTH  = 8
) (
    input  logic                 s00_axi_aclk,
    input  logic                 s00_axi_aresetn,
    input  logic                 cfg_enable,
    input  logic                 cfg_polarity,
    input  logic                 cfg_comp_en,
    input  logic                 cfg_irq_en,
    input  logic [CNT_WIDTH-1:0] cfg_period,
    input  logic [CNT_WIDTH-1:0] cfg_duty,
    input  logic [DT_WIDTH-1:0]  cfg_deadtime,
    input  logic                 cfg_update,
    input  logic                 irq_clr,
    output logic                 pwm_h,
    output logic                 pwm_l,
    output logic                 irq,
    output logic [CNT_WIDTH-1:0] cnt_value
);

    typedef enum logic [1:0] {
        ST_LOW     = 2'd0,
        ST_DT_RISE = 2'd1,
        ST_HIGH    = 2'd2,
        ST_DT_FALL = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;
    localparam logic [DT_WIDTH-1:0]  DT_ONE  = 1;

    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] r_period_sh;
    logic [CNT_WIDTH-1:0] r_duty_sh;
    logic [DT_WIDTH-1:0]  r_dt_sh;
    logic [DT_WIDTH-1:0]  r_dtc;
    logic                 r_pending;
    state_t               r_state;
    logic                 r_pwm_h;
    logic                 r_pwm_l;
    logic                 r_irq;

    logic                 w_wrap;
    logic                 w_load;
    logic                 w_raw;
    logic                 w_dt_zero;
    logic                 w_dtc_zero;
    logic [DT_WIDTH-1:0]  w_dt_init;

    assign w_wrap     = cfg_enable && (r_cnt == r_period_sh);
    // Shadows track cfg_* while stopped; while running they only change at a period boundary.
    assign w_load     = !cfg_enable || (w_wrap && (r_pending || cfg_update));
    assign w_raw      = (r_cnt < r_duty_sh);
    assign w_dt_zero  = (r_dt_sh == '0);
    assign w_dtc_zero = (r_dtc == '0);
    assign w_dt_init  = r_dt_sh - DT_ONE;

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            r_cnt       <= '0;
            r_period_sh <= '0;
            r_duty_sh   <= '0;
            r_dt_sh     <= '0;
            r_pending   <= 1'b0;
            r_irq       <= 1'b0;
        end else begin
            if (w_load) begin
                r_period_sh <= cfg_period;
                r_duty_sh   <= cfg_duty;
                r_dt_sh     <= cfg_deadtime;
                r_pending   <= 1'b0;
            end else if (cfg_update) begin
                r_pending   <= 1'b1;
            end

            if (!cfg_enable || w_wrap) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_ONE;
            end

            // A set on wrap outranks a clear in the same cycle.
            if (w_wrap && cfg_irq_en) begin
                r_irq <= 1'b1;
            end else if (irq_clr) begin
                r_irq <= 1'b0;
            end
        end
    end

    // Outputs default to inactive (= polarity) and are driven active only by the state being entered.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            r_state <= ST_LOW;
            r_dtc   <= '0;
            r_pwm_h <= 1'b0;
            r_pwm_l <= 1'b0;
        end else begin
            r_pwm_h <= cfg_polarity;
            r_pwm_l <= cfg_polarity;
            if (!cfg_enable || !cfg_comp_en) begin
                r_state <= ST_LOW;
                r_dtc   <= '0;
                if (cfg_enable && w_raw) begin
                    r_pwm_h <= ~cfg_polarity;
                end
            end else begin
                case (r_state)
                    ST_LOW: begin
                        if (w_raw) begin
                            if (w_dt_zero) begin
                                r_state <= ST_HIGH;
                                r_pwm_h <= ~cfg_polarity;
                            end else begin
                                r_state <= ST_DT_RISE;
                                r_dtc   <= w_dt_init;
                            end
                        end else begin
                            r_pwm_l <= ~cfg_polarity;
                        end
                    end
                    ST_DT_RISE: begin
                        if (!w_raw) begin
                            r_state <= ST_LOW;
                            r_pwm_l <= ~cfg_polarity;
                        end else if (w_dtc_zero) begin
                            r_state <= ST_HIGH;
                            r_pwm_h <= ~cfg_polarity;
                        end else begin
                            r_dtc <= r_dtc - DT_ONE;
                        end
                    end
                    ST_HIGH: begin
                        if (!w_raw) begin
                            if (w_dt_zero) begin
                                r_state <= ST_LOW;
                                r_pwm_l <= ~cfg_polarity;
                            end else begin
                                r_state <= ST_DT_FALL;
                                r_dtc   <= w_dt_init;
                            end
                        end else begin
                            r_pwm_h <= ~cfg_polarity;
                        end
                    end
                    ST_DT_FALL: begin
                        if (w_raw) begin
                            r_state <= ST_HIGH;
                            r_pwm_h <= ~cfg_polarity;
                        end else if (w_dtc_zero) begin
                            r_state <= ST_LOW;
                            r_pwm_l <= ~cfg_polarity;
                        end else begin
                            r_dtc <= r_dtc - DT_ONE;
                        end
                    end
                    default: begin
                        r_state <= ST_LOW;
                    end
                endcase
            end
        end
    end

    assign pwm_h     = r_pwm_h;
    assign pwm_l     = r_pwm_l;
    assign irq       = r_irq;
    assign cnt_value = r_cnt;

endmodule

// File: tb/tb_pwm_gen_channel.sv
// tb/tb_pwm_gen_channel.sv - self-checking bench for pwm_gen_channel
module tb_pwm_gen_channel;

    localparam int CW = 16;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_enable = 1'b0;
    logic          cfg_polarity = 1'b0;
    logic          cfg_comp_en = 1'b0;
    logic          cfg_irq_en = 1'b0;
    logic [CW-1:0] cfg_period = '0;
    logic [CW-1:0] cfg_duty = '0;
    logic [DW-1:0] cfg_deadtime = '0;
    logic          cfg_update = 1'b0;
    logic          irq_clr = 1'b0;
    logic          pwm_h;
    logic          pwm_l;
    logic          irq;
    logic [CW-1:0] cnt_value;

    always #5 clk = ~clk;

    pwm_gen_channel #(.CNT_WIDTH(CW), .DT_WIDTH(DW)) dut (
        .s00_axi_aclk    (clk),
        .s00_axi_aresetn (rst_n),
        .cfg_enable      (cfg_enable),
        .cfg_polarity    (cfg_polarity),
        .cfg_comp_en     (cfg_comp_en),
        .cfg_irq_en      (cfg_irq_en),
        .cfg_period      (cfg_period),
        .cfg_duty        (cfg_duty),
        .cfg_deadtime    (cfg_deadtime),
        .cfg_update      (cfg_update),
        .irq_clr         (irq_clr),
        .pwm_h           (pwm_h),
        .pwm_l           (pwm_l),
        .irq             (irq),
        .cnt_value       (cnt_value)
    );

    typedef struct {
        int period;
        int duty;
        int dt;
        bit comp;
        bit pol;
        int exp_hi;
        int exp_lo;
    } vec_t;

    typedef struct {
        logic h;
        logic l;
        int   cnt;
    } exp_t;

    exp_t sb[$];
    int   cnt_sb[$];
    int   n_checks = 0;
    int   n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Expected pin levels at phase p of a steady period, from the waveform description.
    function automatic logic [1:0] exp_hl(input int p, input int duty, input int dt,
                                          input bit comp, input bit pol);
        logic h;
        logic l;
        if (!comp) begin
            h = (p < duty);
            l = 1'b0;
        end else if (dt >= duty) begin
            h = 1'b0;
            l = (p >= duty);
        end else begin
            h = (p >= dt) && (p < duty);
            l = (p >= duty + dt);
        end
        return {h ^ pol, l ^ pol};
    endfunction

    task automatic set_cfg(input int period, input int duty, input int dt,
                           input bit comp, input bit pol, input bit irq_en);
        cfg_period   = CW'(period);
        cfg_duty     = CW'(duty);
        cfg_deadtime = DW'(dt);
        cfg_comp_en  = comp;
        cfg_polarity = pol;
        cfg_irq_en   = irq_en;
    endtask

    vec_t       tab[9];
    exp_t       e;
    logic [1:0] hl;
    int         n;
    int         hi;
    int         lo;

    initial begin
        tab[0] = '{9, 3, 0, 1'b0, 1'b0, 3, 0};
        tab[1] = '{9, 0, 0, 1'b0, 1'b0, 0, 0};
        tab[2] = '{9, 12, 0, 1'b0, 1'b0, 10, 0};
        tab[3] = '{0, 1, 0, 1'b0, 1'b0, 1, 0};
        tab[4] = '{19, 10, 2, 1'b1, 1'b0, 8, 8};
        tab[5] = '{19, 10, 2, 1'b1, 1'b1, 8, 8};
        tab[6] = '{9, 2, 3, 1'b1, 1'b0, 0, 8};
        tab[7] = '{9, 5, 0, 1'b1, 1'b0, 5, 5};
        tab[8] = '{9, 3, 0, 1'b0, 1'b1, 3, 0};

        repeat (3) @(negedge clk);
        chk("rst_h", pwm_h, 0);
        chk("rst_l", pwm_l, 0);
        chk("rst_irq", irq, 0);
        chk("rst_cnt", cnt_value, 0);
        rst_n = 1'b1;

        for (int v = 0; v < 9; v++) begin
            @(negedge clk);
            cfg_enable = 1'b0;
            set_cfg(tab[v].period, tab[v].duty, tab[v].dt, tab[v].comp, tab[v].pol, 1'b0);
            @(negedge clk);
            chk($sformatf("v%0d_dis_h", v), pwm_h, tab[v].pol);
            chk($sformatf("v%0d_dis_l", v), pwm_l, tab[v].pol);
            chk($sformatf("v%0d_dis_cnt", v), cnt_value, 0);
            cfg_enable = 1'b1;
            n = tab[v].period + 1;
            hi = 0;
            lo = 0;
            for (int k = 0; k < 2 * n; k++) begin
                hl = exp_hl(k % n, tab[v].duty, tab[v].dt, tab[v].comp, tab[v].pol);
                sb.push_back('{hl[1], hl[0], (k + 1) % n});
                @(negedge clk);
                e = sb.pop_front();
                chk($sformatf("v%0d_k%0d_h", v, k), pwm_h, e.h);
                chk($sformatf("v%0d_k%0d_l", v, k), pwm_l, e.l);
                chk($sformatf("v%0d_k%0d_cnt", v, k), cnt_value, e.cnt);
                if (tab[v].comp)
                    chk($sformatf("v%0d_k%0d_overlap", v, k),
                        (pwm_h ^ tab[v].pol) & (pwm_l ^ tab[v].pol), 0);
                if (k >= n) begin
                    hi += int'(pwm_h ^ tab[v].pol);
                    lo += int'(pwm_l ^ tab[v].pol);
                end
            end
            chk($sformatf("v%0d_hi_count", v), hi, tab[v].exp_hi);
            chk($sformatf("v%0d_lo_count", v), lo, tab[v].exp_lo);
        end

        // Buffered duty update mid-period, then an update coincident with wrap.
        @(negedge clk);
        cfg_enable = 1'b0;
        set_cfg(9, 3, 0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        cfg_enable = 1'b1;
        cnt_sb.push_back(3);
        cnt_sb.push_back(7);
        cnt_sb.push_back(2);
        hi = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            hi += int'(pwm_h);
            if (k == 3) begin
                chk("upd_cnt_at_4", cnt_value, 4);
                cfg_duty = CW'(7);
                cfg_update = 1'b1;
            end
            if (k == 18) begin
                chk("upd_cnt_at_9", cnt_value, 9);
                cfg_duty = CW'(2);
                cfg_update = 1'b1;
            end
            if (k == 4 || k == 19) cfg_update = 1'b0;
            if (k % 10 == 9) begin
                chk($sformatf("upd_period%0d_hi", k / 10), hi, cnt_sb.pop_front());
                hi = 0;
            end
        end

        // Interrupt set/clear priority and stickiness.
        @(negedge clk);
        cfg_enable = 1'b0;
        set_cfg(9, 3, 0, 1'b0, 1'b0, 1'b1);
        irq_clr = 1'b1;
        @(negedge clk);
        irq_clr = 1'b0;
        chk("irq_cleared_init", irq, 0);
        cfg_enable = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k == 8) begin
                chk("irq_pre_wrap_cnt", cnt_value, 9);
                chk("irq_pre_wrap", irq, 0);
                irq_clr = 1'b1;
            end
            if (k == 9) begin
                chk("irq_set_and_clr", irq, 1);
                chk("irq_wrap_cnt", cnt_value, 0);
            end
        end
        @(negedge clk);
        chk("irq_clr_alone", irq, 0);
        irq_clr = 1'b0;
        repeat (9) @(negedge clk);
        chk("irq_rewrap", irq, 1);
        cfg_irq_en = 1'b0;
        repeat (12) @(negedge clk);
        chk("irq_sticky_en_off", irq, 1);

        // One-cycle period: irq on every wrap, output constant high.
        @(negedge clk);
        cfg_enable = 1'b0;
        set_cfg(0, 1, 0, 1'b0, 1'b0, 1'b1);
        irq_clr = 1'b1;
        @(negedge clk);
        chk("p0_irq_clear", irq, 0);
        cfg_enable = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("p0_irq_%0d", k), irq, 1);
            chk($sformatf("p0_h_%0d", k), pwm_h, 1);
            chk($sformatf("p0_cnt_%0d", k), cnt_value, 0);
        end
        irq_clr = 1'b0;

        // Disable at cnt=5, then re-enable restarts a full period.
        @(negedge clk);
        cfg_enable = 1'b0;
        set_cfg(19, 10, 2, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        cfg_enable = 1'b1;
        repeat (5) @(negedge clk);
        chk("dis_mid_cnt5", cnt_value, 5);
        chk("dis_mid_h_before", pwm_h, 1);
        cfg_enable = 1'b0;
        @(negedge clk);
        chk("dis_mid_cnt", cnt_value, 0);
        chk("dis_mid_h", pwm_h, 0);
        chk("dis_mid_l", pwm_l, 0);
        cfg_enable = 1'b1;
        for (int k = 0; k < 20; k++) begin
            hl = exp_hl(k, 10, 2, 1'b1, 1'b0);
            sb.push_back('{hl[1], hl[0], (k + 1) % 20});
            @(negedge clk);
            e = sb.pop_front();
            chk($sformatf("reen_k%0d_h", k), pwm_h, e.h);
            chk($sformatf("reen_k%0d_l", k), pwm_l, e.l);
            chk($sformatf("reen_k%0d_cnt", k), cnt_value, e.cnt);
        end

        // Asynchronous reset at cnt=5 with inverted outputs and irq pending.
        @(negedge clk);
        cfg_enable = 1'b0;
        set_cfg(9, 3, 0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        cfg_enable = 1'b1;
        repeat (15) @(negedge clk);
        chk("arst_pre_cnt", cnt_value, 5);
        chk("arst_pre_irq", irq, 1);
        chk("arst_pre_l", pwm_l, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_cnt", cnt_value, 0);
        chk("arst_h", pwm_h, 0);
        chk("arst_l", pwm_l, 0);
        chk("arst_irq", irq, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cfg_enable = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pwm_gen_channel.md
Name: pwm_gen_channel

Overview:
- Single-channel PWM generator that consumes the configuration registers exposed by the pwm_core AXI4-Lite slave interface.
- It is the stage directly downstream of the register bank and produces the physical PWM output pins.
- Provides double-buffered period/duty, a complementary output with dead-time insertion, programmable polarity and a sticky period-end interrupt.
- All logic runs on the AXI clock; the register bank drives cfg_* and pulses cfg_update on any write to the period, duty or deadtime registers.

Parameters:
CNT_WIDTH, 16, width of period/duty/counter
DT_WIDTH, 8, width of dead-time count

Ports:
s00_axi_aclk  in  1  clock
s00_axi_aresetn  in  1  asynchronous active-low reset
cfg_enable  in  1  run/stop (ctrl bit0)
cfg_polarity  in  1  1 = invert both outputs (ctrl bit1)
cfg_comp_en  in  1  enable complementary output with dead time (ctrl bit2)
cfg_irq_en  in  1  enable period-end interrupt (ctrl bit3)
cfg_period  in  CNT_WIDTH  terminal count; period length = cfg_period+1 cycles
cfg_duty  in  CNT_WIDTH  high cycles per period
cfg_deadtime  in  DT_WIDTH  dead-time cycles
cfg_update  in  1  one-cycle pulse: new period/duty/deadtime pending
irq_clr  in  1  one-cycle pulse: clear irq
pwm_h  out  1  primary PWM output
pwm_l  out  1  complementary PWM output
irq  out  1  sticky period-end interrupt
cnt_value  out  CNT_WIDTH  current counter, for status readback

Behaviour:
- Reset (async assert, sync release): cnt=0; shadows period_sh/duty_sh/dt_sh=0; pending=0; FSM=LOW; pwm_h=pwm_l=0; irq=0.
- Shadow load: period_sh/duty_sh/dt_sh load from cfg_* when (a) cfg_enable=0, every cycle; or (b) wrap occurs and (pending or cfg_update) is true. A load clears pending.
  - cfg_update outside a load cycle sets pending.
  - cfg_update coinciding with wrap takes effect at that wrap.
- Counter: while cfg_enable=1, cnt increments each cycle. When cnt==period_sh, next cnt=0 and wrap=1 for that cycle.
  - cfg_enable=0 forces cnt=0 and wrap=0.
  - Counter wraps at period_sh only; never overflows.
- Compare: raw = (cnt < duty_sh), unsigned, CNT_WIDTH wide.
  - duty_sh=0 gives 0%.
  - duty_sh>period_sh gives 100% (raw constant 1).
  - period_sh=0 gives 1-cycle period; output follows duty!=0.
- Output FSM, comp_en=1. States are LOW, DT_RISE, HIGH, DT_FALL; dtc is the dead-time counter.
  - LOW: h=0, l=1. On raw=1: if dt_sh=0 go to HIGH, else go to DT_RISE with dtc=dt_sh-1.
  - DT_RISE: h=0, l=0. If raw=0, go to LOW. Else if dtc=0, go to HIGH. Else dtc--.
  - HIGH: h=1, l=0. On raw=0: if dt_sh=0 go to LOW, else go to DT_FALL with dtc=dt_sh-1.
  - DT_FALL: h=0, l=0. If raw=1, go to HIGH. Else if dtc=0, go to LOW. Else dtc--.
- comp_en=0: FSM bypassed; h=raw, l=0, no dead time.
- Outputs are registered: pwm_h/pwm_l = state-derived levels XOR cfg_polarity, registered, giving 1 cycle latency from the cnt value that caused the change.
- Disable: cfg_enable=0 forces FSM=LOW, pwm_h=0^pol and pwm_l=0^pol on the next edge (both outputs inactive). Re-enable starts with cnt=0 on the first enabled cycle, using freshly loaded shadows.
- Dead-time truncation: if the high or low phase is shorter than dt_sh, the DT state returns to its originating state and never asserts both outputs. pwm_h and pwm_l are never simultaneously active.
- irq: set on wrap when cfg_irq_en=1; cleared by irq_clr. Set and clear in the same cycle leaves irq=1. Clearing cfg_irq_en does not clear irq.
- cnt_value = cnt, combinational from the register.

Test Plan:
- Basic duty: period=9, duty=3, comp_en=0, pol=0, enable. Required: pwm_h high exactly 3 of every 10 cycles, rising 1 cycle after cnt=0; pwm_l=0.
- Buffered update: running at period=9, duty=3; write duty=7 with cfg_update at cnt=4. Required: current period keeps 3 high cycles; next period shows 7 high cycles. Also update coincident with wrap takes effect immediately.
- Boundaries: duty=0 gives pwm_h constant 0. duty=12 with period=9 gives constant 1. period=0, duty=1 gives constant 1 with irq set every cycle.
- Dead time: period=19, duty=10, comp_en=1, deadtime=2. Required: l falls, h rises 2 cycles later, h high 8 cycles, 2 dead cycles, l high 8 cycles. No overlap; h/l never both 1.
- Polarity and irq: pol=1 inverts both outputs. irq sets at wrap with irq_en=1; irq_clr in the same cycle as wrap leaves irq=1; irq_clr alone clears it.
- Reset and disable mid-operation:
  - Assert aresetn low at cnt=5: outputs, irq and cnt go to 0 immediately (asynchronous).
  - Deassert cfg_enable at cnt=5: cnt=0 and outputs inactive on the next edge; re-enable restarts a full period from cnt=0.
